toggle_line_decoder: RTL

//  Receive-side counterpart of the toggle (transition) line encoder: a decoded 1 is a level change
//  on line_in, a decoded 0 is no change. Recovers bits on each bit_en strobe, hunts for a sync word,

---
 rtl/toggle_line_decoder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/toggle_line_decoder.sv
// Transition-line receiver: recovers bits from level changes, hunts for a sync byte, then
// deserialises LSB-first payload bytes onto a valid/ready port. Optional macro: NRZI_UNSTUFF_EN.
module toggle_line_decoder #(
    parameter logic [7:0]  SYNC_WORD  = 8'hD5,
    parameter int unsigned IDLE_LIMIT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       bit_en,
    input  logic       line_in,
    input  logic       data_ready,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_active,
    output logic       frame_end,
    output logic       overrun,
    output logic       stuff_err
);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    localparam logic [7:0] LP_IDLE = 8'(IDLE_LIMIT);

    state_t     r_state;
    logic       r_last_level;
    logic [7:0] r_sync_sr;
    logic [7:0] r_byte_sr;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_zero_run;
    logic [7:0] r_data_out;
    logic       r_data_valid;
    logic       r_frame_active;
    logic       r_frame_end;
    logic       r_overrun;
`ifdef NRZI_UNSTUFF_EN
    logic [2:0] r_ones_run;
    logic       r_stuff_err;
`endif

    logic       w_dbit;
    logic [7:0] w_sync_next;
    logic [7:0] w_byte_next;
    logic [7:0] w_zero_next;
    logic       w_idle_hit;
    logic       w_xfer;
    logic       w_payload;

    // Next-value helpers for the decoded bit and the run/shift registers
    always_comb begin
        w_dbit      = line_in ^ r_last_level;
        w_sync_next = {w_dbit, r_sync_sr[7:1]};
        w_byte_next = {w_dbit, r_byte_sr[7:1]};
        w_xfer      = r_data_valid & data_ready;
        if (w_dbit) begin
            w_zero_next = 8'd0;
        end else if (r_zero_run == 8'hFF) begin
            w_zero_next = r_zero_run;
        end else begin
            w_zero_next = r_zero_run + 8'd1;
        end
        w_idle_hit = ~w_dbit & (w_zero_next == LP_IDLE);
        w_payload  = 1'b1;
`ifdef NRZI_UNSTUFF_EN
        // After six ones the next bit is a stuff slot, never payload
        w_payload  = (r_ones_run != 3'd6);
`endif
    end

    // Bit recovery, framing state machine, byte assembly and output handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_HUNT;
            r_last_level   <= 1'b0;
            r_sync_sr      <= 8'd0;
            r_byte_sr      <= 8'd0;
            r_bit_cnt      <= 3'd0;
            r_zero_run     <= 8'd0;
            r_data_out     <= 8'd0;
            r_data_valid   <= 1'b0;
            r_frame_active <= 1'b0;
            r_frame_end    <= 1'b0;
            r_overrun      <= 1'b0;
`ifdef NRZI_UNSTUFF_EN
            r_ones_run     <= 3'd0;
            r_stuff_err    <= 1'b0;
`endif
        end else begin
            r_frame_end <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef NRZI_UNSTUFF_EN
            r_stuff_err <= 1'b0;
`endif
            if (w_xfer) begin
                r_data_valid <= 1'b0;
            end
            if (bit_en) begin
                r_last_level <= line_in;
                case (r_state)
                    ST_HUNT: begin
                        r_sync_sr <= w_sync_next;
                        if (w_sync_next == SYNC_WORD) begin
                            r_state        <= ST_DATA;
                            r_frame_active <= 1'b1;
                            r_bit_cnt      <= 3'd0;
                            r_zero_run     <= 8'd0;
                            r_byte_sr      <= 8'd0;
`ifdef NRZI_UNSTUFF_EN
                            r_ones_run     <= 3'd0;
`endif
                        end
                    end
                    ST_DATA: begin
`ifdef NRZI_UNSTUFF_EN
                        if (r_ones_run == 3'd6) begin
                            r_ones_run <= 3'd0;
                            if (w_dbit) begin
                                r_stuff_err    <= 1'b1;
                                r_state        <= ST_HUNT;
                                r_frame_active <= 1'b0;
                                r_sync_sr      <= 8'd0;
                                r_byte_sr      <= 8'd0;
                                r_bit_cnt      <= 3'd0;
                                r_zero_run     <= 8'd0;
                            end
                        end else begin
                            r_ones_run <= w_dbit ? (r_ones_run + 3'd1) : 3'd0;
                        end
`endif
                        if (w_payload) begin
                            r_byte_sr  <= w_byte_next;
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            r_zero_run <= w_zero_next;
                            // Idle close wins over a byte completing on the same bit
                            if (w_idle_hit) begin
                                r_state        <= ST_HUNT;
                                r_frame_active <= 1'b0;
                                r_frame_end    <= 1'b1;
                                r_sync_sr      <= 8'd0;
                                r_byte_sr      <= 8'd0;
                                r_bit_cnt      <= 3'd0;
                                r_zero_run     <= 8'd0;
                            end else if (r_bit_cnt == 3'd7) begin
                                if (!r_data_valid || data_ready) begin
                                    r_data_out   <= w_byte_next;
                                    r_data_valid <= 1'b1;
                                end else begin
                                    r_overrun <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_HUNT;
                    end
                endcase
            end
        end
    end

    assign data_out     = r_data_out;
    assign data_valid   = r_data_valid;
    assign frame_active = r_frame_active;
    assign frame_end    = r_frame_end;
    assign overrun      = r_overrun;
`ifdef NRZI_UNSTUFF_EN
    assign stuff_err    = r_stuff_err;
`else
    assign stuff_err    = 1'b0;
`endif

endmodule
